// File: rtl/alu_serial.sv
// alu_serial: bit-serial AND/OR/ADD/SUB unit, LSB first, one result bit per clock.
// Operands are latched on accept and shifted right so that bit 0 always feeds the
// 1-bit datapath; the carry flop carries between bits. Results appear on R/C/Z
// only when the last bit has been processed.
module alu_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       S,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic             C,
  output logic             Z
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_e;

  state_e          state;
  op_e             op;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             cy;

  logic             xb;
  logic             yb;
  logic             carry_next;
  logic             r_bit;
  logic [WIDTH-1:0] res_next;

  // One-bit datapath: SUB adds the inverted y bit, with the carry flop preset to 1.
  always_comb begin
    xb         = a_sh[0];
    yb         = b_sh[0] ^ (op == OP_SUB);
    carry_next = (xb & yb) | (cy & (xb ^ yb));
    r_bit      = 1'b0;
    case (op)
      OP_AND:  r_bit = a_sh[0] & b_sh[0];
      OP_OR:   r_bit = a_sh[0] | b_sh[0];
      default: r_bit = xb ^ yb ^ cy;
    endcase
    res_next = {r_bit, res[WIDTH-1:1]};
  end

  // Control FSM with registered busy/done and result outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      op    <= OP_AND;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      R     <= '0;
      C     <= 1'b0;
      Z     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= x;
            b_sh  <= y;
            op    <= op_e'(S);
            cy    <= (S == 2'b11);
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= res_next;
          cy   <= carry_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            R     <= res_next;
            C     <= (op == OP_ADD || op == OP_SUB) ? carry_next : 1'b0;
            Z     <= (res_next == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed and randomized checks of alu_serial against an
// arithmetic reference model.
module tb_alu_serial;

  localparam int W = 8;

  logic         clk;
  logic         nrst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [1:0]   S;
  logic         busy;
  logic         done;
  logic [W-1:0] R;
  logic         C;
  logic         Z;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  alu_serial #(.WIDTH(W)) dut (
    .clk(clk), .nrst(nrst), .start(start), .x(x), .y(y), .S(S),
    .busy(busy), .done(done), .R(R), .C(C), .Z(Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: {Z, C, R} from plain arithmetic.
  function automatic logic [W+1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    case (op)
      2'd0: begin r = a & b; c = 1'b0; end
      2'd1: begin r = a | b; c = 1'b0; end
      2'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
      default: begin r = a - b; c = (a >= b); end
    endcase
    return {(r == '0), c, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE, optionally scrambling inputs during RUN.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit scramble);
    logic [W+1:0] e;
    logic [W-1:0] r_hold;
    int           lat;
    e     = model(op, a, b);
    nrst  = 1'b1;
    start = 1'b1;
    x = a; y = b; S = op;
    tick();
    start = 1'b0;
    check("accept_busy", {31'd0, busy}, 32'd1);
    check("accept_done", {31'd0, done}, 32'd0);
    r_hold = R;
    lat = 0;
    for (int k = 1; k <= W + 4; k++) begin
      if (scramble) begin
        x = W'($urandom); y = W'($urandom); S = 2'($urandom); start = 1'($urandom);
      end
      tick();
      if (done) begin
        lat = k;
        break;
      end
      check("r_hold_run", {{(32-W){1'b0}}, R}, {{(32-W){1'b0}}, r_hold});
    end
    start = 1'b0;
    check("latency", lat, W);
    check("result_R", {{(32-W){1'b0}}, R}, {{(32-W){1'b0}}, e[W-1:0]});
    check("result_C", {31'd0, C}, {31'd0, e[W]});
    check("result_Z", {31'd0, Z}, {31'd0, e[W+1]});
    check("done_busy", {31'd0, busy}, 32'd0);
    tick();
    check("done_single", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  logic [1:0]   bb_op [3];
  logic [W-1:0] bb_a  [3];
  logic [W-1:0] bb_b  [3];
  logic [W+1:0] e;
  int           done_cyc [3];
  int           nd;
  bit           prev_done;
  bit           saw_done;

  initial begin
    nrst = 1'b0; start = 1'b0; x = '0; y = '0; S = '0;
    tick();
    start = 1'b1;  // reset must win over start
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_R", {{(32-W){1'b0}}, R}, 32'd0);
    check("rst_C", {31'd0, C}, 32'd0);
    check("rst_Z", {31'd0, Z}, 32'd0);

    // First accept on the first edge with nrst high, then directed vectors.
    run_op(2'd2, 8'hFF, 8'h01, 1'b0);
    check("add_ff_01", {23'd0, C, R}, {23'd0, 1'b1, 8'h00});
    run_op(2'd3, 8'h05, 8'h07, 1'b0);
    check("sub_5_7", {22'd0, Z, C, R}, {22'd0, 1'b0, 1'b0, 8'hFE});
    run_op(2'd3, 8'h07, 8'h05, 1'b0);
    check("sub_7_5", {23'd0, C, R}, {23'd0, 1'b1, 8'h02});
    run_op(2'd0, 8'hA5, 8'h0F, 1'b0);
    check("and_a5_0f", {23'd0, C, R}, {23'd0, 1'b0, 8'h05});
    run_op(2'd1, 8'hA5, 8'h0F, 1'b0);
    check("or_a5_0f", {23'd0, Z, R}, {23'd0, 1'b0, 8'hAF});
    run_op(2'd3, 8'h3C, 8'h3C, 1'b1);  // equal SUB: zero with no borrow

    // Randomized operations, every other one with inputs scrambled during RUN.
    for (int i = 0; i < 24; i++)
      run_op(2'($urandom), W'($urandom), W'($urandom), bit'(i % 2));

    // Reset in the 4th RUN cycle aborts with no done pulse.
    run_op(2'd2, 8'h77, 8'h11, 1'b0);
    start = 1'b1; x = 8'h99; y = 8'h44; S = 2'd2;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_R", {{(32-W){1'b0}}, R}, 32'd0);
    check("abort_CZ", {30'd0, C, Z}, 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_quiet", {31'd0, saw_done}, 32'd0);
    run_op(2'd2, 8'h10, 8'h20, 1'b0);
    check("add_10_20", {{(32-W){1'b0}}, R}, 32'h30);

    // start held high: three operations back to back.
    for (int i = 0; i < 3; i++) begin
      bb_op[i] = 2'($urandom); bb_a[i] = W'($urandom); bb_b[i] = W'($urandom);
    end
    x = bb_a[0]; y = bb_b[0]; S = bb_op[0]; start = 1'b1;
    nd = 0;
    prev_done = 1'b0;
    for (int k = 0; k < 40 && nd < 3; k++) begin
      tick();
      check("b2b_busy", {31'd0, busy}, {31'd0, !(done || prev_done)});
      prev_done = done;
      if (done) begin
        e = model(bb_op[nd], bb_a[nd], bb_b[nd]);
        check("b2b_result", {22'd0, Z, C, R}, {22'd0, e});
        done_cyc[nd] = cyc;
        nd++;
        if (nd < 3) begin
          x = bb_a[nd]; y = bb_b[nd]; S = bb_op[nd];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_count", nd, 3);
    if (nd == 3) begin
      check("b2b_gap1", done_cyc[1] - done_cyc[0], W + 2);
      check("b2b_gap2", done_cyc[2] - done_cyc[1], W + 2);
    end
    tick();
    check("b2b_end_done", {31'd0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 nrst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 x  input  WIDTH  operand A; sampled on the edge that accepts start.
REQ-006 y  input  WIDTH  operand B; sampled on the edge that accepts start.
REQ-007 S  input  2  operation select: 00 AND, 01 OR, 10 ADD, 11 SUB (x - y); sampled with x, y.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse when R, C and Z become valid.
REQ-010 R  output  WIDTH  registered result; holds the last completed value.
REQ-011 C  output  1  carry flag; ADD carry-out, SUB no-borrow (1 = x >= y unsigned), 0 for AND/OR.
REQ-012 Z  output  1  zero flag; 1 when the completed R equals 0.

Function
REQ-013 The block SHALL compute the result bit-serially, LSB first, one result bit per clock, using a single 1-bit datapath plus a carry flop.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE: start=1 SHALL latch x, y and S into internal registers, clear the bit counter, and move to RUN on the same edge; start=0 SHALL keep the FSM in IDLE.
REQ-016 Carry flop init on accept SHALL be 1 for SUB and 0 for all other operations.
REQ-017 SUB SHALL use the inverted y bit in the adder, giving x + ~y + 1.
REQ-018 RUN: each edge SHALL process operand bit i (counter = i), shift the result bit into the internal result register, update the carry flop and increment the counter.
REQ-019 RUN: on the edge that processes bit WIDTH-1, the FSM SHALL load R, C and Z from the final values and move to DONE.
REQ-020 Latency: done SHALL be high in the cycle after the WIDTH-th rising edge following the edge that accepted start.
REQ-021 DONE SHALL last exactly one cycle, with done=1 and busy=0, and SHALL always return to IDLE.
REQ-022 start SHALL be ignored in RUN and DONE; it is not queued; x, y and S changes in those states SHALL NOT affect the result.
REQ-023 If start is held high, the next operation SHALL be accepted on the first IDLE edge; back-to-back throughput is one operation per WIDTH+2 cycles.
REQ-024 R, C and Z SHALL change only on the RUN-to-DONE edge and on reset; they SHALL hold stable during RUN.
REQ-025 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-026 Result width: arithmetic SHALL wrap modulo 2^WIDTH; the carry out of bit WIDTH-1 SHALL go to C only.

Reset
REQ-027 nrst=0 at a rising edge SHALL force IDLE, busy=0, done=0, R=0, C=0, Z=0, and clear the counter, carry flop and internal registers.
REQ-028 Reset SHALL take priority over start and SHALL abort an operation in RUN; no done pulse is produced for the aborted operation.
REQ-029 The first start SHALL be accepted on the first edge with nrst=1.

Verification (WIDTH=8)
REQ-030 ADD x=8'hFF, y=8'h01 -> done exactly 8 edges after the accept edge; R=8'h00, C=1, Z=1.
REQ-031 SUB x=8'h05, y=8'h07 -> R=8'hFE, C=0, Z=0; SUB x=8'h07, y=8'h05 -> R=8'h02, C=1.
REQ-032 AND x=8'hA5, y=8'h0F -> R=8'h05, C=0; OR with the same operands -> R=8'hAF, Z=0.
REQ-033 Pulse start and change x, y, S during RUN -> result matches the originally latched operands; one done pulse only; R stable until DONE.
REQ-034 Reset at the 4th RUN cycle -> next cycle all outputs 0 and state IDLE, no done pulse; a new ADD 8'h10+8'h20 afterwards -> R=8'h30.
REQ-035 start held high for 3 operations -> done pulses spaced 10 cycles apart; busy low only in DONE and the IDLE accept cycle.
